// File: rtl/mem_bus_pkg.sv
// Shared types and default address map for the RAM / switch / LED memory bus.
package mem_bus_pkg;

   // Default I/O addresses (bit 8 set means "not RAM")
   localparam logic [8:0] LED_ADDR = 9'h100;
   localparam logic [8:0] SW_ADDR  = 9'h140;

   typedef enum logic [1:0] {
      MNONE  = 2'b00,
      MREAD  = 2'b01,
      MWRITE = 2'b10
   } mem_cmd_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      RESP   = 2'b10
   } arb_state_t;

   typedef enum logic {
      CPU = 1'b0,
      DBG = 1'b1
   } owner_t;

   // Round-robin pick: a lone requester wins; on a tie the side that did not
   // own the bus last time wins.
   function automatic owner_t pick_owner(input logic cpu_pend, input logic dbg_pend,
                                         input owner_t last);
      if (cpu_pend && dbg_pend) return (last == DBG) ? CPU : DBG;
      else if (dbg_pend)        return DBG;
      else                      return CPU;
   endfunction

endpackage

// File: rtl/mem_io_regs.sv
// LED register, switch read path and RAM-versus-I/O decode for the latched
// bus address.
module mem_io_regs #(
   parameter int                    DATA_WIDTH = 16,
   parameter int                    ADDR_WIDTH = 9,
   parameter logic [ADDR_WIDTH-1:0] LED_ADDR   = mem_bus_pkg::LED_ADDR,
   parameter logic [ADDR_WIDTH-1:0] SW_ADDR    = mem_bus_pkg::SW_ADDR
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] addr,       // latched transaction address
   input  logic                  wr_en,      // high only in ACCESS of a write
   input  logic [7:0]            led_wdata,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   input  logic [7:0]            sw,
   output logic                  is_ram,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [7:0]            led
);

   logic [7:0] led_d, led_q;

   assign is_ram = ~addr[ADDR_WIDTH-1];
   assign led    = led_q;

   // LED load on a write to its address; other I/O writes fall on the floor
   always_comb begin
      led_d = led_q;
      if (wr_en && addr == LED_ADDR) led_d = led_wdata;
   end

   // LED register, cleared by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) led_q <= '0;
      else       led_q <= led_d;
   end

   // Read mux: RAM, switches, LED readback, else zero
   always_comb begin
      rd_data = '0;
      if (is_ram)                rd_data = ram_dout;
      else if (addr == SW_ADDR)  rd_data = {{(DATA_WIDTH-8){1'b0}}, sw};
      else if (addr == LED_ADDR) rd_data = {{(DATA_WIDTH-8){1'b0}}, led_q};
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (CPU / debug) arbiter for the single-port RAM and switch/LED I/O.
// Every access runs IDLE -> ACCESS -> RESP; the winner gets a one-cycle
// ready/valid pulse in RESP with read data muxed from RAM or I/O.
module mem_bus_arbiter #(
   parameter int                    DATA_WIDTH = 16,
   parameter int                    ADDR_WIDTH = 9,
   parameter logic [ADDR_WIDTH-1:0] LED_ADDR   = mem_bus_pkg::LED_ADDR,
   parameter logic [ADDR_WIDTH-1:0] SW_ADDR    = mem_bus_pkg::SW_ADDR
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            cpu_cmd,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_ready,
   input  logic                  dbg_req,
   input  logic                  dbg_we,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   input  logic [DATA_WIDTH-1:0] dbg_wdata,
   output logic [DATA_WIDTH-1:0] dbg_rdata,
   output logic                  dbg_valid,
   output logic [ADDR_WIDTH-2:0] ram_addr,
   output logic                  ram_write,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   input  logic [7:0]            SW,
   output logic [7:0]            LEDR
);
   import mem_bus_pkg::*;

   arb_state_t            state_d, state_q;
   owner_t                owner_d, owner_q;
   owner_t                last_owner_d, last_owner_q;
   owner_t                grant;
   logic                  wr_d, wr_q;
   logic [ADDR_WIDTH-1:0] addr_d, addr_q;
   logic [DATA_WIDTH-1:0] din_d, din_q;
   logic                  cpu_ready_d, cpu_ready_q;
   logic                  dbg_valid_d, dbg_valid_q;
   logic                  cpu_pend, dbg_pend;
   logic                  io_is_ram;
   logic [DATA_WIDTH-1:0] io_rd_data, resp_data;

   assign cpu_pend = (cpu_cmd != MNONE);
   assign dbg_pend = dbg_req;
   assign grant    = pick_owner(cpu_pend, dbg_pend, last_owner_q);

   // Next-state: latch the winner's request at grant, pulse ready on the way to RESP
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      wr_d         = wr_q;
      addr_d       = addr_q;
      din_d        = din_q;
      cpu_ready_d  = 1'b0;
      dbg_valid_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cpu_pend || dbg_pend) begin
               owner_d      = grant;
               last_owner_d = grant;
               if (grant == CPU) begin
                  wr_d   = (cpu_cmd == MWRITE);
                  addr_d = cpu_addr;
                  din_d  = cpu_wdata;
               end else begin
                  wr_d   = dbg_we;
                  addr_d = dbg_addr;
                  din_d  = dbg_wdata;
               end
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            cpu_ready_d = (owner_q == CPU);
            dbg_valid_d = (owner_q == DBG);
            state_d     = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM, arbitration history, latched request and registered completion pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= CPU;
         last_owner_q <= DBG;   // CPU wins the first tie
         wr_q         <= 1'b0;
         addr_q       <= '0;
         din_q        <= '0;
         cpu_ready_q  <= 1'b0;
         dbg_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         wr_q         <= wr_d;
         addr_q       <= addr_d;
         din_q        <= din_d;
         cpu_ready_q  <= cpu_ready_d;
         dbg_valid_q  <= dbg_valid_d;
      end
   end

   mem_io_regs #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .LED_ADDR   (LED_ADDR),
      .SW_ADDR    (SW_ADDR)
   ) u_io (
      .clk       (clk),
      .reset     (reset),
      .addr      (addr_q),
      .wr_en     ((state_q == ACCESS) && wr_q),
      .led_wdata (din_q[7:0]),
      .ram_dout  (ram_dout),
      .sw        (SW),
      .is_ram    (io_is_ram),
      .rd_data   (io_rd_data),
      .led       (LEDR)
   );

   // RAM strobe comes only from flops, so an async reset before the ACCESS
   // edge drops state to IDLE and kills the write.
   assign ram_addr  = addr_q[ADDR_WIDTH-2:0];
   assign ram_din   = din_q;
   assign ram_write = (state_q == ACCESS) && wr_q && io_is_ram;

   // RAM read data only arrives in RESP, so the return path is combinational
   assign resp_data = ((state_q == RESP) && !wr_q) ? io_rd_data : '0;
   assign cpu_rdata = (owner_q == CPU) ? resp_data : '0;
   assign dbg_rdata = (owner_q == DBG) ? resp_data : '0;
   assign cpu_ready = cpu_ready_q;
   assign dbg_valid = dbg_valid_q;

endmodule
